mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 29 ++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_t    - arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   PORT_I/D   - one-bit port identifiers used for grants and the
//                last-grant pointer
//   other_port - returns the opposite port id
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection.
// Ports:
//   i_req, d_req - current requests from fetch and data ports
//   last_grant   - port that was granted most recently
//   grant        - selected port id (only meaningful when a request is high)
// On conflict the port not granted last wins. Tying last_grant to PORT_I
// turns this into a fixed D-over-I priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant
);

    // Winner selection from the present request vector
    always_comb begin
        grant = PORT_I;
        if (i_req && d_req) begin
            grant = other_port(last_grant);
        end else if (d_req) begin
            grant = PORT_D;
        end else begin
            grant = PORT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch port (I) and
// a load/store port (D).
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   i_req/i_addr/i_flush             - fetch request, address, squash
//   i_ready/i_rdata                  - fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata        - load/store request
//   d_ready/d_rdata                  - data completion pulse and load data
//   mem_req/mem_we/mem_addr/mem_wdata- memory request side
//   mem_ack/mem_rdata                - memory completion and read data
// Configuration macro MEM_ARB_RR_EN: defined -> round-robin on conflict,
// undefined -> fixed priority D over I (no pointer register).
// Arbitration happens only in IDLE; every transaction is followed by one
// IDLE cycle. Ready pulses are combinational from mem_ack so the minimum
// request-to-ready latency is one cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ready,
    output logic [XLEN-1:0]   i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_ready,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic [XLEN-1:0]   wdata_r;
    logic              squash_r;
    logic              grant_s;
    logic              last_s;
    logic              grant_now_s;

    assign grant_now_s = (state_r == IDLE) && (i_req || d_req);

`ifdef MEM_ARB_RR_EN
    logic last_r;

    // Round-robin pointer: remembers the port of every grant
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r <= PORT_I;
        end else if (grant_now_s) begin
            last_r <= grant_s;
        end else begin
            last_r <= last_r;
        end
    end

    assign last_s = last_r;
`else
    // Constant pointer makes the picker resolve conflicts to D
    assign last_s = PORT_I;
`endif

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_s),
        .grant      (grant_s)
    );

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_req || d_req) begin
                    state_s = (grant_s == PORT_D) ? BUSY_D : BUSY_I;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and capture of the winning request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            we_r    <= 1'b0;
            wdata_r <= {XLEN{1'b0}};
        end else begin
            state_r <= state_s;
            if (grant_now_s) begin
                if (grant_s == PORT_D) begin
                    addr_r  <= d_addr;
                    we_r    <= d_we;
                    wdata_r <= d_wdata;
                end else begin
                    addr_r  <= i_addr;
                    we_r    <= 1'b0;
                    wdata_r <= {XLEN{1'b0}};
                end
            end
        end
    end

    // Squash flag: set by a flush during a fetch, cleared when the fetch ends
    always_ff @(posedge clk) begin
        if (reset) begin
            squash_r <= 1'b0;
        end else if (state_r == BUSY_I) begin
            squash_r <= (squash_r || i_flush) && !mem_ack;
        end else begin
            squash_r <= 1'b0;
        end
    end

    // Output decode; everything is forced to zero while reset is high
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {XLEN{1'b0}};
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        i_rdata   = {XLEN{1'b0}};
        d_rdata   = {XLEN{1'b0}};
        if (!reset) begin
            mem_req   = (state_r == BUSY_I) || (state_r == BUSY_D);
            mem_we    = (state_r == BUSY_D) && we_r;
            mem_addr  = addr_r;
            mem_wdata = wdata_r;
            // A flush in the ack cycle itself also suppresses the pulse
            i_ready   = (state_r == BUSY_I) && mem_ack && !squash_r && !i_flush;
            d_ready   = (state_r == BUSY_D) && mem_ack;
            i_rdata   = i_ready ? mem_rdata : {XLEN{1'b0}};
            d_rdata   = d_ready ? mem_rdata : {XLEN{1'b0}};
        end else begin
            mem_req   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model each cycle.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_arbiter #(.ADDR_W(32), .XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: one outstanding access or none.
    bit          m_busy   = 1'b0;
    bit          m_is_d   = 1'b0;
    bit          m_squash = 1'b0;
    bit          m_last_d = 1'b0;
    bit          m_we     = 1'b0;
    logic [31:0] m_addr   = 32'h0;
    logic [31:0] m_wdata  = 32'h0;
    bit          exp_ir   = 1'b0;
    bit          exp_dr   = 1'b0;

    bit auto_mode = 1'b0;
    int mcnt = 0;
    int mlat = 0;
    int ready_cnt = 0;
    int both_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model for the current cycle, then advance model.
    task automatic check_and_step();
        bit eir;
        bit edr;
        bit win_d;
        eir = 1'b0;
        edr = 1'b0;
        if (reset) begin
            chk("rst_mem_req", mem_req, 32'd0);
            chk("rst_mem_we", mem_we, 32'd0);
            chk("rst_i_ready", i_ready, 32'd0);
            chk("rst_d_ready", d_ready, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_i_rdata", i_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
        end else begin
            eir = m_busy && !m_is_d && mem_ack && !m_squash && !i_flush;
            edr = m_busy && m_is_d && mem_ack;
            chk("mem_req", mem_req, {31'd0, m_busy});
            chk("i_ready", i_ready, {31'd0, eir});
            chk("d_ready", d_ready, {31'd0, edr});
            if (m_busy) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", mem_we, {31'd0, m_we});
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (eir) chk("i_rdata", i_rdata, mem_rdata);
            if (edr) chk("d_rdata", d_rdata, mem_rdata);
        end
        if (i_ready === 1'b1) ready_cnt++;
        if (d_ready === 1'b1) ready_cnt++;
        if (i_ready === 1'b1 && d_ready === 1'b1) both_cnt++;

        if (reset) begin
            m_busy   = 1'b0;
            m_squash = 1'b0;
            m_last_d = 1'b0;
        end else if (!m_busy) begin
            if (i_req || d_req) begin
                if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                    win_d = !m_last_d;
`else
                    win_d = 1'b1;
`endif
                end else begin
                    win_d = d_req;
                end
                m_is_d   = win_d;
                m_last_d = win_d;
                m_busy   = 1'b1;
                m_squash = 1'b0;
                m_addr   = win_d ? d_addr : i_addr;
                m_we     = win_d ? d_we : 1'b0;
                m_wdata  = d_wdata;
            end
        end else begin
            if (!m_is_d && i_flush) m_squash = 1'b1;
            if (mem_ack) begin
                m_busy   = 1'b0;
                m_squash = 1'b0;
            end
        end
        exp_ir = eir;
        exp_dr = edr;
    endtask

    // Random requesters and memory, following the handshake rules.
    task automatic drive_random();
        reset = ($urandom_range(0, 299) == 0);
        if (exp_ir) begin
            if ($urandom_range(0, 1) == 0) i_req = 1'b0;
            else i_addr = $urandom;
        end else if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = $urandom;
        end
        i_flush = ($urandom_range(0, 5) == 0);
        if (exp_dr) begin
            if ($urandom_range(0, 1) == 0) begin
                d_req = 1'b0;
            end else begin
                d_addr  = $urandom;
                d_we    = $urandom_range(0, 1) == 1;
                d_wdata = $urandom;
            end
        end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req   = 1'b1;
            d_addr  = $urandom;
            d_we    = $urandom_range(0, 1) == 1;
            d_wdata = $urandom;
        end
        if (m_busy) begin
            mem_ack = (mcnt == mlat);
            mcnt++;
        end else begin
            mcnt    = 0;
            mlat    = $urandom_range(0, 3);
            mem_ack = ($urandom_range(0, 7) == 0);
        end
        mem_rdata = $urandom;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_and_step();
        @(posedge clk);
        #1;
        if (auto_mode) drive_random();
    endtask

    initial begin
        logic [31:0] exp_seq [4];
        reset = 1'b1; i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Single fetch, ack two cycles after mem_req rises
        i_req = 1'b1; i_addr = 32'h0000_0100;
        cycle();
        #1;
        chk("fetch_req", mem_req, 32'd1);
        chk("fetch_addr", mem_addr, 32'h0000_0100);
        chk("fetch_we", mem_we, 32'd0);
        chk("fetch_early_ready", i_ready, 32'd0);
        cycle();
        cycle();
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        #1;
        chk("fetch_ready", i_ready, 32'd1);
        chk("fetch_rdata", i_rdata, 32'h0050_0093);
        cycle();
        i_req = 1'b0; mem_ack = 1'b0;
        #1;
        chk("fetch_ready_pulse", i_ready, 32'd0);
        chk("fetch_idle_gap", mem_req, 32'd0);
        cycle();

        // Conflict after reset: D first, then I
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_0300;
        d_req = 1'b1; d_addr = 32'h0000_0400; d_we = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        cycle();
        #1;
        chk("conflict_first_d", mem_addr, 32'h0000_0400);
        chk("conflict_d_ready", d_ready, 32'd1);
        chk("conflict_no_i_ready", i_ready, 32'd0);
        cycle();
        d_req = 1'b0;
        #1;
        chk("conflict_gap", mem_req, 32'd0);
        cycle();
        #1;
        chk("conflict_then_i", mem_addr, 32'h0000_0300);
        chk("conflict_i_ready", i_ready, 32'd1);
        cycle();
        i_req = 1'b0; mem_ack = 1'b0;
        cycle();

        // Both held for four grants
        reset = 1'b1;
        cycle();
        reset = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_seq = '{32'h0000_0400, 32'h0000_0300, 32'h0000_0400, 32'h0000_0300};
`else
        exp_seq = '{32'h0000_0400, 32'h0000_0400, 32'h0000_0400, 32'h0000_0400};
`endif
        i_req = 1'b1; d_req = 1'b1; mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            #1;
            chk("held_order", mem_addr, exp_seq[k]);
            cycle();
        end
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        cycle();
        cycle();

        // Store with stable address/data until ack
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            cycle();
            #1;
            chk("store_we", mem_we, 32'd1);
            chk("store_addr", mem_addr, 32'h0000_2000);
            chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("store_wait", d_ready, 32'd0);
        end
        cycle();
        mem_ack = 1'b1;
        #1;
        chk("store_done", d_ready, 32'd1);
        chk("store_addr_ack", mem_addr, 32'h0000_2000);
        cycle();
        d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        cycle();

        // Flush one cycle before ack, then redirected fetch
        i_req = 1'b1; i_addr = 32'h0000_0180;
        cycle();
        cycle();
        i_flush = 1'b1; i_addr = 32'h0000_0200;
        #1;
        chk("flush_cycle_ready", i_ready, 32'd0);
        cycle();
        i_flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("flush_squashed", i_ready, 32'd0);
        chk("flush_access_done", mem_req, 32'd1);
        cycle();
        mem_ack = 1'b0;
        #1;
        chk("flush_gap", mem_req, 32'd0);
        cycle();
        mem_ack = 1'b1; mem_rdata = 32'h00C0_0113;
        #1;
        chk("refetch_addr", mem_addr, 32'h0000_0200);
        chk("refetch_ready", i_ready, 32'd1);
        chk("refetch_rdata", i_rdata, 32'h00C0_0113);
        cycle();
        i_req = 1'b0; mem_ack = 1'b0;
        cycle();

        // Reset in the middle of a load, then a stray ack
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
        cycle();
        #1;
        chk("midrst_busy", mem_req, 32'd1);
        cycle();
        reset = 1'b1; d_req = 1'b0;
        #1;
        chk("midrst_req_low", mem_req, 32'd0);
        chk("midrst_no_ready", d_ready, 32'd0);
        cycle();
        reset = 1'b0;
        cycle();
        mem_ack = 1'b1;
        #1;
        chk("stray_ack_ready", d_ready, 32'd0);
        chk("stray_ack_req", mem_req, 32'd0);
        cycle();
        mem_ack = 1'b0;
        #1;
        chk("after_stray_req", mem_req, 32'd0);
        cycle();

        // Zero-wait memory, both requesters always asking
        mem_ack = 1'b1; i_req = 1'b1; d_req = 1'b1;
        i_addr = 32'h0000_0040; d_addr = 32'h0000_0080; d_we = 1'b0;
        ready_cnt = 0; both_cnt = 0;
        repeat (20) cycle();
        chk("zero_wait_ready_count", ready_cnt, 32'd10);
        chk("zero_wait_never_both", both_cnt, 32'd0);
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        cycle();
        cycle();

        // Randomized traffic
        auto_mode = 1'b1;
        repeat (5000) cycle();
        auto_mode = 1'b0;
        reset = 1'b1;
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
